// File: rtl/pixel_combinator.sv
// Raster-order pixel combinator: broadcasts the next expected coordinate to the
// reorder queues and funnels released colours into a small output FIFO.
module pixel_combinator #(
    parameter int DATA_WIDTH  = 32,
    parameter int RBG_SIZE    = 24,
    parameter int NUM_ENGINES = 4,
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_ENGINES-1:0]          queue_en,
    input  logic [NUM_ENGINES*RBG_SIZE-1:0] queue_colour,
    output logic [DATA_WIDTH-1:0]           xpixel_check,
    output logic [DATA_WIDTH-1:0]           ypixel_check,
    output logic [RBG_SIZE-1:0]             pix_data,
    output logic                            pix_sop,
    output logic                            pix_eop,
    output logic                            pix_valid,
    input  logic                            pix_ready,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            multi_hit
);
    // state | meaning
    // IDLE  | sentinel on check bus, waiting for start
    // SCAN  | presenting (x,y) while FIFO has room, capturing hits
    // DRAIN | last pixel captured, waiting for FIFO to empty

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(IMG_W - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(IMG_H - 1);
    localparam logic [DATA_WIDTH-1:0] SENT_X = DATA_WIDTH'(IMG_W);
    localparam logic [DATA_WIDTH-1:0] SENT_Y = DATA_WIDTH'(IMG_H);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] x, y, x_next, y_next;
    logic [RBG_SIZE-1:0]   fifo_data [OUT_DEPTH];
    logic                  fifo_sop  [OUT_DEPTH];
    logic                  fifo_eop  [OUT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  hit, multi, push, pop, fifo_full, at_first, at_last;
    logic [RBG_SIZE-1:0]   hit_colour;

    assign at_first  = (x == '0) && (y == '0);
    assign at_last   = (x == X_LAST) && (y == Y_LAST);
    assign fifo_full = (count == CNT_W'(OUT_DEPTH));
    assign multi     = |(queue_en & (queue_en - NUM_ENGINES'(1)));

    // Descending scan so the lowest set index is the one that sticks.
    always_comb begin
        hit_colour = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (queue_en[i]) hit_colour = queue_colour[i*RBG_SIZE +: RBG_SIZE];
        end
    end

    always_comb begin
        state_next   = state;
        x_next       = x;
        y_next       = y;
        hit          = 1'b0;
        frame_done   = 1'b0;
        busy         = (state != IDLE);
        xpixel_check = SENT_X;
        ypixel_check = SENT_Y;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    x_next     = '0;
                    y_next     = '0;
                end
            end
            SCAN: begin
                if (!fifo_full) begin
                    xpixel_check = x;
                    ypixel_check = y;
                end
                if (|queue_en) begin
                    hit = 1'b1;
                    if (at_last) begin
                        state_next = DRAIN;
                    end else if (x == X_LAST) begin
                        x_next = '0;
                        y_next = y + DATA_WIDTH'(1);
                    end else begin
                        x_next = x + DATA_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (count == '0) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            multi_hit <= 1'b0;
        end else begin
            state <= state_next;
            x     <= x_next;
            y     <= y_next;
            if (hit && multi) multi_hit <= 1'b1;
        end
    end

    assign push = hit && !fifo_full;
    assign pop  = pix_valid && pix_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= hit_colour;
            fifo_sop[wr_ptr]  <= at_first;
            fifo_eop[wr_ptr]  <= at_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign pix_valid = (count != '0);
    assign pix_data  = pix_valid ? fifo_data[rd_ptr] : '0;
    assign pix_sop   = pix_valid ? fifo_sop[rd_ptr]  : 1'b0;
    assign pix_eop   = pix_valid ? fifo_eop[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_pixel_combinator.sv
// Bench for pixel_combinator on a 4x2 frame fed by two modelled reorder queues
// (engine0 owns even x, engine1 odd x); outputs are scoreboarded in raster order.
module tb_pixel_combinator;
    localparam int DW = 32;
    localparam int CW = 24;
    localparam int NE = 2;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int SX = 4;
    localparam int SY = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [NE-1:0]     queue_en;
    logic [NE*CW-1:0]  queue_colour;
    logic [DW-1:0]     xck, yck;
    logic [CW-1:0]     pix_data;
    logic              pix_sop, pix_eop, pix_valid;
    logic              pix_ready = 1'b0;
    logic              busy, frame_done, multi_hit;

    pixel_combinator #(.DATA_WIDTH(DW), .RBG_SIZE(CW), .NUM_ENGINES(NE),
                       .IMG_W(W), .IMG_H(H), .OUT_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .queue_en(queue_en),
        .queue_colour(queue_colour), .xpixel_check(xck), .ypixel_check(yck),
        .pix_data(pix_data), .pix_sop(pix_sop), .pix_eop(pix_eop),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy),
        .frame_done(frame_done), .multi_hit(multi_hit));

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int frame_id = 0;
    int n_out  = 0;
    logic [CW+1:0] sb[$];
    int out_cyc[$];
    int cx[$], cy[$];
    bit fd_seen, valid_at_fd, prev_at_fd, busy_after;
    int fd_pulses;

    // queue model and override path
    logic          reload = 1'b0, hold1 = 1'b0, ovr = 1'b0;
    logic [NE-1:0] ovr_en = '0;
    logic [CW-1:0] ovr_a = '0, ovr_b = '0;
    logic [NE-1:0] m_en;
    logic [CW-1:0] m_col [NE];
    int            head [NE];

    function automatic logic [CW-1:0] colour(input int px, input int py);
        return {8'(frame_id), 8'(py), 8'(px)};
    endfunction

    assign queue_en     = ovr ? ovr_en : m_en;
    assign queue_colour = ovr ? {ovr_b, ovr_a} : {m_col[1], m_col[0]};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset || reload) begin
            m_en    <= '0;
            head[0] <= 0;
            head[1] <= 0;
        end else begin
            for (int e = 0; e < NE; e++) begin
                if ((2*head[e]+e) < W*H && !(e == 1 && hold1) &&
                    xck == DW'((2*head[e]+e) % W) && yck == DW'((2*head[e]+e) / W)) begin
                    m_en[e]  <= 1'b1;
                    m_col[e] <= colour((2*head[e]+e) % W, (2*head[e]+e) / W);
                    head[e]  <= head[e] + 1;
                end else begin
                    m_en[e] <= 1'b0;
                end
            end
        end
    end

    // scoreboard consumer
    always @(negedge clk) begin
        if (!reset && pix_valid && pix_ready) begin
            n_out++;
            out_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got %h with nothing expected", {pix_sop, pix_eop, pix_data});
            end else begin
                logic [CW+1:0] exp;
                exp = sb.pop_front();
                if ({pix_sop, pix_eop, pix_data} !== exp) begin
                    fails++;
                    $display("FAIL pixel_out: got %h expected %h", {pix_sop, pix_eop, pix_data}, exp);
                end
            end
        end
    end

    task automatic start_frame();
        @(posedge clk); #1;
        frame_id++;
        for (int p = 0; p < W*H; p++)
            sb.push_back({p == 0, p == W*H-1, colour(p % W, p / W)});
        out_cyc.delete();
        start = 1'b1; reload = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reload = 1'b0;
    endtask

    task automatic collect_frame(input int start_at, input int budget);
        logic prev_valid;
        prev_valid = 1'b0;
        cx.delete(); cy.delete();
        fd_seen = 0; fd_pulses = 0; valid_at_fd = 0; prev_at_fd = 0; busy_after = 1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            start = (k == start_at);
            @(negedge clk);
            if (!(xck == SX && yck == SY))
                if (cx.size() == 0 || cx[$] != int'(xck) || cy[$] != int'(yck)) begin
                    cx.push_back(int'(xck));
                    cy.push_back(int'(yck));
                end
            if (frame_done) begin
                if (!fd_seen) begin valid_at_fd = pix_valid; prev_at_fd = prev_valid; end
                fd_seen = 1;
                fd_pulses++;
            end else if (fd_seen) begin
                busy_after = busy;
                break;
            end
            prev_valid = pix_valid;
        end
        start = 1'b0;
    endtask

    task automatic wait_coord(input int ex, input int ey, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (xck == DW'(ex) && yck == DW'(ey)) ok = 1;
        end
    endtask

    task automatic check_sequence(input string name);
        checks++;
        if (cx.size() != W*H) begin
            fails++;
            $display("FAIL %s_len: got %0d coordinates expected %0d", name, cx.size(), W*H);
        end
        for (int i = 0; i < W*H && i < cx.size(); i++) begin
            checks++;
            if (cx[i] != i % W || cy[i] != i / W) begin
                fails++;
                $display("FAIL %s_coord[%0d]: got (%0d,%0d) expected (%0d,%0d)", name, i, cx[i], cy[i], i % W, i / W);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({pix_valid, pix_sop, pix_eop, busy, frame_done, multi_hit} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000", {pix_valid, pix_sop, pix_eop, busy, frame_done, multi_hit});
        end
        checks++;
        if (xck !== DW'(SX) || yck !== DW'(SY)) begin
            fails++;
            $display("FAIL reset_sentinel: got (%0d,%0d) expected (%0d,%0d)", xck, yck, SX, SY);
        end
        checks++;
        if (pix_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", pix_data);
        end
    endtask

    task automatic test_raster();
        pix_ready = 1'b1;
        start_frame();
        collect_frame(-1, 60);
        checks++;
        if (!fd_seen) begin fails++; $display("FAIL raster_frame_done: not seen within budget"); end
        check_sequence("raster");
        checks++;
        if (out_cyc.size() != W*H) begin
            fails++;
            $display("FAIL raster_out_count: got %0d expected %0d", out_cyc.size(), W*H);
        end
        for (int i = 1; i < out_cyc.size(); i++) begin
            checks++;
            if (out_cyc[i] - out_cyc[i-1] != 2) begin
                fails++;
                $display("FAIL raster_gap[%0d]: got %0d cycles expected 2", i, out_cyc[i] - out_cyc[i-1]);
            end
        end
        checks++;
        if (fd_pulses != 1 || valid_at_fd !== 1'b0 || prev_at_fd !== 1'b1) begin
            fails++;
            $display("FAIL raster_done_timing: got pulses=%0d valid=%0d prev_valid=%0d expected 1,0,1", fd_pulses, valid_at_fd, prev_at_fd);
        end
        checks++;
        if (busy_after !== 1'b0) begin fails++; $display("FAIL raster_busy_after: got %0d expected 0", busy_after); end
        checks++;
        if (sb.size() != 0) begin fails++; $display("FAIL raster_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n0;
        n0 = n_out;
        pix_ready = 1'b0;
        start_frame();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 14 || k == 29) begin
                checks++;
                if ({pix_valid, pix_sop, pix_eop, pix_data} !== {3'b110, colour(0, 0)}) begin
                    fails++;
                    $display("FAIL bp_head_stable: got %h expected %h", {pix_valid, pix_sop, pix_eop, pix_data}, {3'b110, colour(0, 0)});
                end
            end
        end
        checks++;
        if (xck !== DW'(SX) || yck !== DW'(SY)) begin
            fails++;
            $display("FAIL bp_sentinel: got (%0d,%0d) expected (%0d,%0d)", xck, yck, SX, SY);
        end
        checks++;
        if (head[0] + head[1] != 4) begin
            fails++;
            $display("FAIL bp_pops: got %0d queue pops expected 4", head[0] + head[1]);
        end
        @(posedge clk); #1 pix_ready = 1'b1;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (!(xck == SX && yck == SY)) ok = 1;
        end
        checks++;
        if (!ok || xck !== 0 || yck !== 1) begin
            fails++;
            $display("FAIL bp_resume: got (%0d,%0d) expected (0,1)", xck, yck);
        end
        collect_frame(-1, 60);
        checks++;
        if (!fd_seen || n_out - n0 != W*H || sb.size() != 0) begin
            fails++;
            $display("FAIL bp_complete: got done=%0d outputs=%0d left=%0d expected 1,%0d,0", fd_seen, n_out - n0, sb.size(), W*H);
        end
    endtask

    task automatic test_withhold();
        bit ok;
        int n0;
        n0 = n_out;
        pix_ready = 1'b1;
        hold1 = 1'b1;
        start_frame();
        wait_coord(1, 0, 20, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL hold_reach: (1,0) not presented within budget"); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (xck !== 1 || yck !== 0) begin
                fails++;
                $display("FAIL hold_coord[%0d]: got (%0d,%0d) expected (1,0)", k, xck, yck);
            end
        end
        checks++;
        if (n_out - n0 != 1) begin
            fails++;
            $display("FAIL hold_no_advance: got %0d outputs expected 1", n_out - n0);
        end
        @(posedge clk); #1 hold1 = 1'b0;
        collect_frame(-1, 60);
        checks++;
        if (!fd_seen || sb.size() != 0) begin
            fails++;
            $display("FAIL hold_complete: got done=%0d left=%0d expected 1,0", fd_seen, sb.size());
        end
    endtask

    task automatic test_start_ignored();
        pix_ready = 1'b1;
        start_frame();
        collect_frame(6, 60);
        checks++;
        if (!fd_seen || sb.size() != 0) begin
            fails++;
            $display("FAIL restart_complete: got done=%0d left=%0d expected 1,0", fd_seen, sb.size());
        end
        check_sequence("restart");
    endtask

    task automatic test_multi_hit();
        ovr = 1'b1;
        pix_ready = 1'b1;
        ovr_a = 24'hAAAA01;
        ovr_b = 24'hBBBB02;
        @(posedge clk); #1 ovr_en = 2'b11;
        @(posedge clk); #1 ovr_en = 2'b00;
        @(negedge clk);
        checks++;
        if ({multi_hit, pix_valid, busy} !== 3'b000) begin
            fails++;
            $display("FAIL idle_en_ignored: got %b expected 000", {multi_hit, pix_valid, busy});
        end
        frame_id++;
        sb.push_back({2'b10, ovr_a});
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; ovr_en = 2'b11;
        @(posedge clk); #1 ovr_en = 2'b00;
        @(negedge clk);
        checks++;
        if (multi_hit !== 1'b1 || xck !== 1 || yck !== 0) begin
            fails++;
            $display("FAIL multi_set: got flag=%0d at (%0d,%0d) expected 1 at (1,0)", multi_hit, xck, yck);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (multi_hit !== 1'b1 || sb.size() != 0) begin
            fails++;
            $display("FAIL multi_sticky: got flag=%0d left=%0d expected 1,0", multi_hit, sb.size());
        end
        @(posedge clk); #1 reset = 1'b1; ovr = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (multi_hit !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL multi_cleared: got flag=%0d busy=%0d expected 0,0", multi_hit, busy);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        pix_ready = 1'b1;
        start_frame();
        wait_coord(1, 0, 20, ok);
        @(posedge clk); #1 pix_ready = 1'b0;
        wait_coord(3, 0, 20, ok);
        checks++;
        if (!ok || {pix_valid, pix_sop, pix_data} !== {2'b10, colour(1, 0)}) begin
            fails++;
            $display("FAIL mid_setup: got reached=%0d head=%h expected 1,%h", ok, {pix_valid, pix_sop, pix_data}, {2'b10, colour(1, 0)});
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || xck !== DW'(SX) || yck !== DW'(SY)) begin
            fails++;
            $display("FAIL mid_reset: got valid=%0d busy=%0d (%0d,%0d) expected 0,0 (%0d,%0d)", pix_valid, busy, xck, yck, SX, SY);
        end
        pix_ready = 1'b1;
        start_frame();
        collect_frame(-1, 60);
        checks++;
        if (!fd_seen || sb.size() != 0) begin
            fails++;
            $display("FAIL mid_restart: got done=%0d left=%0d expected 1,0", fd_seen, sb.size());
        end
        check_sequence("mid_restart");
    endtask

    initial begin
        test_reset();
        test_raster();
        test_backpressure();
        test_withhold();
        test_start_ignored();
        test_multi_hit();
        test_reset_midframe();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
